// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice.
//   alu_op_e    : ALU sel encodings (codes 9..15 are valid and return all-ones)
//   alu_flags_t : {n, z, v} flag triple
//   issue_ctl_t : control half of the issue register (operands live beside it)
package alu_pkg;

    // Wide enough for up to 8 requesters.
    localparam int unsigned ID_W = 3;

    typedef enum logic [3:0] {
        ALU_ZERO  = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_SHR   = 4'd3,
        ALU_SHL   = 4'd4,
        ALU_AND   = 4'd5,
        ALU_OR    = 4'd6,
        ALU_PASSB = 4'd7,
        ALU_PASSA = 4'd8
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [3:0]      op;
        logic            setf;
    } issue_ctl_t;

endpackage

// File: rtl/ALU.sv
// Combinational N-bit ALU.
// Ports:
//   a, b : operands
//   sel  : operation code (alu_op_e; unlisted codes give all-ones)
//   y    : result
//   v    : signed overflow of the adder (add/sub only, 0 otherwise)
module ALU
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   sel,
    output logic [N-1:0] y,
    output logic         v
);

    always_comb begin
        y = '0;
        v = 1'b0;
        case (sel)
            ALU_ZERO:  y = '0;
            ALU_ADD: begin
                y = a + b;
                v = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                y = a - b;
                v = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
            end
            ALU_SHR:   y = a >> b;
            ALU_SHL:   y = a << b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_PASSB: y = b;
            ALU_PASSA: y = a;
            default:   y = '1;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector
//   advance  : a transfer happened this cycle; move the pointer to the winner
//   grant    : one-hot grant (zero when no request)
// The search starts one past the most recently granted port; after reset the
// pointer sits on NREQ-1 so port 0 has first priority.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] last;
    logic [PW-1:0] last_nxt;
    logic          found;

    // Walk offsets 1..NREQ from the pointer; the inner loop maps each offset
    // back to a static port index so every select stays constant-indexed.
    always_comb begin
        grant    = '0;
        last_nxt = last;
        found    = 1'b0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((32'(last) + off) % NREQ) == i)) begin
                    grant[i] = 1'b1;
                    last_nxt = PW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= PW'(NREQ - 1);
        end else if (advance) begin
            last <= last_nxt;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-port request
//   req_ready  : per-port combinational grant (at most one high)
//   req_op     : per-port ALU sel code
//   req_a/b    : per-port operands
//   req_setf   : per-port "update my flag register with this result"
//   rsp_valid  : one-cycle pulse marking the owner of rsp_result
//   rsp_result : shared registered result, held until the next response
//   rsp_flags  : per-port sticky {n,z,v}
//   busy       : issue register holds a valid op
// Pipeline: handshake edge loads the issue register; the next edge registers
// the ALU output and pulses rsp_valid for the issuing port.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned NREQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][3:0]       req_op,
    input  logic [NREQ-1:0][N-1:0]     req_a,
    input  logic [NREQ-1:0][N-1:0]     req_b,
    input  logic [NREQ-1:0]            req_setf,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [N-1:0]               rsp_result,
    output logic [NREQ-1:0][2:0]       rsp_flags,
    output logic                       busy
);

    logic [NREQ-1:0]        grant;
    logic                   transfer;

    logic [ID_W-1:0]        pick_id;
    logic [3:0]             pick_op;
    logic [N-1:0]           pick_a;
    logic [N-1:0]           pick_b;
    logic                   pick_setf;

    issue_ctl_t             iss;
    logic [N-1:0]           iss_a;
    logic [N-1:0]           iss_b;

    logic [N-1:0]           alu_y;
    logic                   alu_v;
    alu_flags_t             alu_flags;
    alu_flags_t [NREQ-1:0]  flag_q;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (transfer),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);

    always_comb begin
        pick_id   = '0;
        pick_op   = '0;
        pick_a    = '0;
        pick_b    = '0;
        pick_setf = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                pick_id   = ID_W'(i);
                pick_op   = req_op[i];
                pick_a    = req_a[i];
                pick_b    = req_b[i];
                pick_setf = req_setf[i];
            end
        end
    end

    // No backpressure: the issue register reloads every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss   <= '0;
            iss_a <= '0;
            iss_b <= '0;
        end else begin
            iss   <= '{valid: transfer, id: pick_id, op: pick_op, setf: pick_setf};
            iss_a <= pick_a;
            iss_b <= pick_b;
        end
    end

    ALU #(
        .N (N)
    ) u_alu (
        .a   (iss_a),
        .b   (iss_b),
        .sel (iss.op),
        .y   (alu_y),
        .v   (alu_v)
    );

    assign alu_flags = '{n: alu_y[N-1], z: (alu_y == '0), v: alu_v};

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            flag_q     <= '0;
        end else begin
            rsp_valid <= '0;
            if (iss.valid) begin
                rsp_result <= alu_y;
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (32'(iss.id) == i) begin
                        rsp_valid[i] <= 1'b1;
                        if (iss.setf) begin
                            flag_q[i] <= alu_flags;
                        end
                    end
                end
            end
        end
    end

    assign rsp_flags = flag_q;
    assign busy      = iss.valid;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int unsigned N    = 32;
    localparam int unsigned NREQ = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][3:0]   req_op;
    logic [NREQ-1:0][N-1:0] req_a;
    logic [NREQ-1:0][N-1:0] req_b;
    logic [NREQ-1:0]        req_setf;
    logic [NREQ-1:0]        rsp_valid;
    logic [N-1:0]           rsp_result;
    logic [NREQ-1:0][2:0]   rsp_flags;
    logic                   busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .N    (N),
        .NREQ (NREQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_setf   (req_setf),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0: return 32'd0;
            1: return a + b;
            2: return a - b;
            3: return (b >= 32) ? 32'd0 : a >> b[4:0];
            4: return (b >= 32) ? 32'd0 : a << b[4:0];
            5: return a & b;
            6: return a | b;
            7: return b;
            8: return a;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic ref_ovf(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 1) r = sa + sb;
        else if (op == 2) r = sa - sb;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_setf  = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic set_req(input int p, input int op, input logic [31:0] a,
                           input logic [31:0] b, input logic setf);
        req_valid[p] = 1'b1;
        req_op[p]    = 4'(op);
        req_a[p]     = a;
        req_b[p]     = b;
        req_setf[p]  = setf;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
        total++; if (rsp_result !== 32'd0) begin bad++; $display("FAIL reset_rsp_result got=%h want=0", rsp_result); end
        total++; if (rsp_flags !== 6'b0) begin bad++; $display("FAIL reset_rsp_flags got=%b want=0", rsp_flags); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        set_req(0, 1, 32'd5, 32'd7, 1'b1);
        @(negedge clk);
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL add_ready got=%b want=01", req_ready); end
        tick();
        idle();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy got=%b want=1", busy); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL add_early_valid got=%b want=00", rsp_valid); end
        tick();
        total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL add_valid got=%b want=01", rsp_valid); end
        total++; if (rsp_result !== 32'd12) begin bad++; $display("FAIL add_result got=%h want=c", rsp_result); end
        total++; if (rsp_flags[0] !== 3'b000) begin bad++; $display("FAIL add_flags got=%b want=000", rsp_flags[0]); end
        tick();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL add_pulse got=%b want=00", rsp_valid); end
        total++; if (rsp_result !== 32'd12) begin bad++; $display("FAIL add_hold got=%h want=c", rsp_result); end

        set_req(1, 2, 32'd3, 32'd3, 1'b1);
        @(negedge clk);
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL sub_ready got=%b want=10", req_ready); end
        tick();
        idle();
        tick();
        total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL sub_valid got=%b want=10", rsp_valid); end
        total++; if (rsp_result !== 32'd0) begin bad++; $display("FAIL sub_result got=%h want=0", rsp_result); end
        total++; if (rsp_flags[1] !== 3'b010) begin bad++; $display("FAIL sub_flags1 got=%b want=010", rsp_flags[1]); end
        total++; if (rsp_flags[0] !== 3'b000) begin bad++; $display("FAIL sub_flags0 got=%b want=000", rsp_flags[0]); end

        set_req(1, 5, 32'h0000_00F0, 32'h0000_003C, 1'b0);
        tick();
        idle();
        tick();
        total++; if (rsp_result !== 32'h30) begin bad++; $display("FAIL and_result got=%h want=30", rsp_result); end
        total++; if (rsp_flags[1] !== 3'b010) begin bad++; $display("FAIL and_flags_kept got=%b want=010", rsp_flags[1]); end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] want;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        set_req(0, 1, 32'd1, 32'd1, 1'b0);
        set_req(1, 6, 32'd4, 32'd8, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (req_ready !== want) begin bad++; $display("FAIL b2b_grant[%0d] got=%b want=%b", k, req_ready, want); end
            total++; if ($countones(req_ready) > 1) begin bad++; $display("FAIL b2b_onehot[%0d] got=%b want=onehot", k, req_ready); end
            tick();
            if (k == 5) idle();
            if (k >= 1) begin
                want = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
                total++; if (rsp_valid !== want) begin bad++; $display("FAIL b2b_rsp[%0d] got=%b want=%b", k, rsp_valid, want); end
                total++; if (rsp_result !== ((want == 2'b01) ? 32'd2 : 32'd12)) begin bad++; $display("FAIL b2b_result[%0d] got=%h", k, rsp_result); end
            end else begin
                total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL b2b_rsp[0] got=%b want=00", rsp_valid); end
            end
        end
        tick();
        total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL b2b_last_rsp got=%b want=10", rsp_valid); end
        total++; if (rsp_result !== 32'd12) begin bad++; $display("FAIL b2b_last_result got=%h want=c", rsp_result); end
        tick();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL b2b_drain got=%b want=00", rsp_valid); end
    endtask

    task automatic test_shift_pass();
        int          ops [4] = '{4, 3, 8, 12};
        logic [31:0] as  [4] = '{32'd1, 32'h8000_0000, 32'hDEAD_BEEF, 32'd0};
        logic [31:0] bs  [4] = '{32'd4, 32'd31, 32'd0, 32'd0};
        logic [31:0] ws  [4] = '{32'd16, 32'd1, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            set_req(0, ops[i], as[i], bs[i], 1'b0);
            tick();
            idle();
            tick();
            total++; if (rsp_result !== ws[i]) begin bad++; $display("FAIL shiftpass_op%0d got=%h want=%h", ops[i], rsp_result, ws[i]); end
            total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL shiftpass_valid_op%0d got=%b want=01", ops[i], rsp_valid); end
        end
    endtask

    task automatic test_overflow();
        set_req(0, 1, 32'h7FFF_FFFF, 32'd1, 1'b1);
        tick();
        idle();
        tick();
        total++; if (rsp_result !== 32'h8000_0000) begin bad++; $display("FAIL ovf_result got=%h want=80000000", rsp_result); end
        total++; if (rsp_flags[0] !== 3'b101) begin bad++; $display("FAIL ovf_flags got=%b want=101", rsp_flags[0]); end
    endtask

    task automatic test_reset_midop();
        set_req(0, 1, 32'd2, 32'd3, 1'b1);
        tick();
        rst = 1'b1;
        idle();
        tick();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rstmid_valid got=%b want=00", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (rsp_result !== 32'd0) begin bad++; $display("FAIL rstmid_result got=%h want=0", rsp_result); end
        total++; if (rsp_flags !== 6'b0) begin bad++; $display("FAIL rstmid_flags got=%b want=0", rsp_flags); end
        rst = 1'b0;
        tick();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rstmid_late_valid got=%b want=00", rsp_valid); end
        set_req(0, 0, 32'd0, 32'd0, 1'b0);
        set_req(1, 0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rstmid_prio got=%b want=01", req_ready); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        int              m_last;
        logic            p_valid;
        int              p_id;
        int              p_op;
        logic            p_setf;
        logic [31:0]     p_res;
        logic            p_v;
        logic [31:0]     exp_res;
        logic [2:0]      ef [NREQ];
        logic            vk [NREQ];
        int              waits [NREQ];
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rv;
        logic [NREQ-1:0] prev_grant;
        logic [2:0]      mask;
        int              g;
        int              op;

        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        m_last     = NREQ - 1;
        p_valid    = 1'b0;
        p_id       = 0;
        p_op       = 0;
        p_setf     = 1'b0;
        p_res      = '0;
        p_v        = 1'b0;
        exp_res    = '0;
        prev_grant = '0;
        for (int p = 0; p < NREQ; p++) begin
            ef[p]    = 3'b000;
            vk[p]    = 1'b1;
            waits[p] = 0;
        end

        for (int c = 0; c < 400; c++) begin
            // Ports still waiting keep their request; others draw a new one.
            for (int p = 0; p < NREQ; p++) begin
                if (!(req_valid[p] && !prev_grant[p])) begin
                    op           = int'($urandom_range(0, 15));
                    req_valid[p] = ($urandom_range(0, 3) != 0);
                    req_op[p]    = 4'(op);
                    req_a[p]     = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
                    req_b[p]     = (op == 3 || op == 4) ? 32'($urandom_range(0, 40))
                                   : (($urandom_range(0, 7) == 0) ? req_a[p] : $urandom);
                    req_setf[p]  = 1'($urandom_range(0, 1));
                end
            end

            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;

            @(negedge clk);
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, req_ready, exp_ready); end

            for (int p = 0; p < NREQ; p++) begin
                if (p == g) begin
                    total++; if (waits[p] > NREQ - 1) begin bad++; $display("FAIL rnd_fair[%0d] port=%0d waited=%0d max=%0d", c, p, waits[p], NREQ - 1); end
                    waits[p] = 0;
                end else if (req_valid[p]) begin
                    waits[p]++;
                end else begin
                    waits[p] = 0;
                end
            end

            tick();

            exp_rv = '0;
            if (p_valid) begin
                exp_rv[p_id] = 1'b1;
                exp_res      = p_res;
                if (p_setf) begin
                    ef[p_id] = {p_res[31], (p_res == 32'd0), p_v};
                    vk[p_id] = (p_op == 1 || p_op == 2);
                end
            end
            p_valid = (g >= 0);
            if (g >= 0) begin
                p_id   = g;
                p_op   = int'(req_op[g]);
                p_setf = req_setf[g];
                p_res  = ref_result(p_op, req_a[g], req_b[g]);
                p_v    = ref_ovf(p_op, req_a[g], req_b[g]);
                m_last = g;
            end
            prev_grant = exp_ready;

            total++; if (rsp_valid !== exp_rv) begin bad++; $display("FAIL rnd_rsp_valid[%0d] got=%b want=%b", c, rsp_valid, exp_rv); end
            total++; if (rsp_result !== exp_res) begin bad++; $display("FAIL rnd_result[%0d] got=%h want=%h", c, rsp_result, exp_res); end
            total++; if (busy !== p_valid) begin bad++; $display("FAIL rnd_busy[%0d] got=%b want=%b", c, busy, p_valid); end
            for (int p = 0; p < NREQ; p++) begin
                mask = vk[p] ? 3'b111 : 3'b110;
                total++; if ((rsp_flags[p] & mask) !== (ef[p] & mask)) begin bad++; $display("FAIL rnd_flags[%0d] port=%0d got=%b want=%b mask=%b", c, p, rsp_flags[p], ef[p], mask); end
            end
        end
        idle();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_back_to_back();
        test_shift_pass();
        test_overflow();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
